// File: rtl/sa_ram_fifo_ctrl.sv
// FIFO controller for an external 1R1W RAM whose ra_d/dout_r registers form a 2-stage read pipeline.
// Optional high-water mark register enabled by defining SA_RAM_FIFO_PEAK_EN.
module sa_ram_fifo_ctrl #(
  parameter int unsigned DEPTH = 80,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 7,
  parameter int unsigned CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    peak,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout
);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, avail;
  logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic          push, pop, adv1, adv2;

  // count only covers committed writes, so avail never issues an address still being written
  assign avail = count_q - CW'(s1_vld_q) - CW'(s2_vld_q);

  always_comb begin
    wr_prdy  = (count_q < CW'(DEPTH));
    push     = wr_pvld & wr_prdy;
    pop      = s2_vld_q & rd_prdy;
    adv2     = s1_vld_q & (~s2_vld_q | rd_prdy);
    adv1     = (avail != '0) & (~s1_vld_q | adv2);
    s1_vld_d = adv1 | (s1_vld_q & ~adv2);
    s2_vld_d = adv2 | (s2_vld_q & ~rd_prdy);
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    if (push) begin
      wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    end
    if (adv1) begin
      rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  assign ram_we  = push;
  assign ram_wa  = wptr_q;
  assign ram_di  = wr_pd;
  assign ram_re  = adv1;
  assign ram_ra  = rptr_q;
  assign ram_ore = adv2;
  assign rd_pvld = s2_vld_q;
  assign rd_pd   = ram_dout;
  assign count   = count_q;

`ifdef SA_RAM_FIFO_PEAK_EN
  logic [CW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else if (count_q > peak_q) begin
      peak_q <= count_q;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule
